// File: rtl/simple_mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : simple_mailbox_fifo
// Description : 32-bit mailbox FIFO slave on the simple read/write bus.
//               Provides DATA (push/pop), STATUS, CTRL and THRESH registers
//               plus a registered threshold interrupt. Decode, error flags
//               and read data are combinational; FIFO state is registered.
//               Optional feature macro: SIMPLE_MAILBOX_PEEK_EN enables the
//               read-only non-destructive PEEK register at offset 0x10.
// Ports       : clk, rst (sync, active-high)
//               write, write_address, write_data, write_byteenable,
//               write_address_error, write_error        - write channel
//               read, read_address, read_data,
//               read_address_error                      - read channel
//               irq                                      - threshold interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module simple_mailbox_fifo #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_byteenable,
    output logic        write_address_error,
    output logic        write_error,
    input  logic        read,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_address_error,
    output logic        irq
);

    localparam int             c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one  = 1;
    localparam logic [c_aw:0]   c_cnt_one  = 1;

    localparam logic [2:0] c_reg_data   = 3'd0;
    localparam logic [2:0] c_reg_status = 3'd1;
    localparam logic [2:0] c_reg_ctrl   = 3'd2;
    localparam logic [2:0] c_reg_thresh = 3'd3;
    localparam logic [2:0] c_reg_peek   = 3'd4;

`ifdef SIMPLE_MAILBOX_PEEK_EN
    localparam logic c_peek_en = 1'b1;
`else
    localparam logic c_peek_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]     mem_q [DEPTH];
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            irq_en_q, irq_en_d;
    logic [8:0]      thresh_q, thresh_d;
    logic            irq_q, irq_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic        w_wr_hit, w_rd_hit;
    logic [2:0]  w_wr_reg, w_rd_reg;
    logic        w_wr_mapped, w_rd_mapped;
    logic        w_empty, w_full;
    logic [31:0] w_head;
    logic [31:0] w_rd_data;
    logic [31:0] w_push_data;
    logic [8:0]  w_count_q_ext, w_count_d_ext;
    logic        w_unused;

    assign w_wr_hit = (write_address[31:5] == BASE_ADDR[31:5]);
    assign w_rd_hit = (read_address[31:5]  == BASE_ADDR[31:5]);
    assign w_wr_reg = write_address[4:2];
    assign w_rd_reg = read_address[4:2];

    // Byte-lane bits [1:0] of the addresses carry no meaning here.
    assign w_unused = &{1'b0, write_address[1:0], read_address[1:0]};

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_depth);
    // Stale memory is never exposed: an empty FIFO reads as zero.
    assign w_head  = w_empty ? 32'h0 : mem_q[rd_ptr_q];

    assign w_count_q_ext = 9'(count_q);
    assign w_count_d_ext = 9'(count_d);

    assign w_wr_mapped = w_wr_hit &&
                         ((w_wr_reg <= c_reg_thresh) ||
                          ((w_wr_reg == c_reg_peek) && c_peek_en));

    always_comb begin
        w_rd_mapped = 1'b0;
        w_rd_data   = 32'h0;
        if (w_rd_hit) begin
            case (w_rd_reg)
                c_reg_data: begin
                    w_rd_mapped = 1'b1;
                    w_rd_data   = w_head;
                end
                c_reg_status: begin
                    w_rd_mapped = 1'b1;
                    w_rd_data   = {15'h0, w_count_q_ext, 3'h0,
                                   irq_q, unf_q, ovf_q, w_full, w_empty};
                end
                c_reg_ctrl: begin
                    w_rd_mapped = 1'b1;
                    w_rd_data   = {23'h0, irq_en_q, 8'h0};
                end
                c_reg_thresh: begin
                    w_rd_mapped = 1'b1;
                    w_rd_data   = {23'h0, thresh_q};
                end
                c_reg_peek: begin
                    w_rd_mapped = c_peek_en;
                    w_rd_data   = c_peek_en ? w_head : 32'h0;
                end
                default: begin
                    w_rd_mapped = 1'b0;
                    w_rd_data   = 32'h0;
                end
            endcase
        end
    end

    assign read_data          = w_rd_data;
    assign read_address_error = read && !w_rd_mapped;

    // ------------------------------------------------------------------
    // Access events
    // ------------------------------------------------------------------
    logic w_ctrl_wr, w_thresh_wr, w_flush, w_clear;
    logic w_rd_data_acc, w_pop, w_unf_evt;
    logic w_push_req, w_push, w_ovf_evt;

    assign w_ctrl_wr   = write && w_wr_hit && (w_wr_reg == c_reg_ctrl);
    assign w_thresh_wr = write && w_wr_hit && (w_wr_reg == c_reg_thresh);
    assign w_flush     = w_ctrl_wr && write_byteenable[0] && write_data[0];
    assign w_clear     = w_ctrl_wr && write_byteenable[0] && write_data[1];

    // A flush in the same cycle swallows the pop and its underflow.
    assign w_rd_data_acc = read && w_rd_hit && (w_rd_reg == c_reg_data);
    assign w_pop         = w_rd_data_acc && !w_empty && !w_flush;
    assign w_unf_evt     = w_rd_data_acc &&  w_empty && !w_flush;

    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign w_push_req = write && w_wr_hit && (w_wr_reg == c_reg_data);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && !w_push;

    assign write_address_error = write && !w_wr_mapped;
    assign write_error         = write && w_wr_mapped &&
                                 ((w_wr_reg == c_reg_status) ||
                                  (w_wr_reg == c_reg_peek)   ||
                                  w_ovf_evt);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_push_data[8*i +: 8] = write_byteenable[i] ? write_data[8*i +: 8] : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;

        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end

        // Clear applies first so an error event in the same cycle is kept.
        if (w_clear) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (w_ovf_evt) begin
            ovf_d = 1'b1;
        end
        if (w_unf_evt) begin
            unf_d = 1'b1;
        end

        if (w_ctrl_wr && write_byteenable[1]) begin
            irq_en_d = write_data[8];
        end
        if (w_thresh_wr && write_byteenable[0]) begin
            thresh_d[7:0] = write_data[7:0];
        end
        if (w_thresh_wr && write_byteenable[1]) begin
            thresh_d[8] = write_data[8];
        end

        irq_d = irq_en_q && (thresh_q != 9'h0) && (w_count_d_ext >= thresh_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= 9'd1;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    // Storage has no reset; contents are only visible through count.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= w_push_data;
        end
    end

    assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_simple_mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_mailbox_fifo
// Description : Self-checking bench for simple_mailbox_fifo. Pushed words go
//               into an expected-data queue; DATA reads pop and compare.
//               Honours SIMPLE_MAILBOX_PEEK_EN for the PEEK register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_mailbox_fifo;

    localparam int          DEPTH     = 16;
    localparam logic [31:0] BASE_ADDR = 32'h8000_0040;

    localparam logic [31:0] c_a_data   = BASE_ADDR + 32'h00;
    localparam logic [31:0] c_a_status = BASE_ADDR + 32'h04;
    localparam logic [31:0] c_a_ctrl   = BASE_ADDR + 32'h08;
    localparam logic [31:0] c_a_thresh = BASE_ADDR + 32'h0C;
    localparam logic [31:0] c_a_peek   = BASE_ADDR + 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [3:0]  write_byteenable;
    logic        write_address_error;
    logic        write_error;
    logic        read;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic        read_address_error;
    logic        irq;

    simple_mailbox_fifo #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .write               (write),
        .write_address       (write_address),
        .write_data          (write_data),
        .write_byteenable    (write_byteenable),
        .write_address_error (write_address_error),
        .write_error         (write_error),
        .read                (read),
        .read_address        (read_address),
        .read_data           (read_data),
        .read_address_error  (read_address_error),
        .irq                 (irq)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q_exp[$];
    logic        ovf_m = 1'b0;
    logic        unf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start at posedge+1, sample 2 ns later and end at posedge+1.
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output logic we, output logic wae);
        write = 1'b1; write_address = addr; write_data = data; write_byteenable = be;
        #2;
        we  = write_error;
        wae = write_address_error;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d, output logic ae);
        read = 1'b1; read_address = addr;
        #2;
        d  = read_data;
        ae = read_address_error;
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    function automatic logic [31:0] mask_be(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
        return m;
    endfunction

    task automatic push_m(input logic [31:0] d, input logic [3:0] be);
        logic we, wae, exp_we;
        exp_we = (q_exp.size() == DEPTH);
        bus_wr(c_a_data, d, be, we, wae);
        check("push_werr", {31'h0, we}, {31'h0, exp_we});
        check("push_waerr", {31'h0, wae}, 32'h0);
        if (exp_we) ovf_m = 1'b1;
        else        q_exp.push_back(mask_be(d, be));
    endtask

    task automatic pop_m();
        logic [31:0] d, exp;
        logic        ae;
        if (q_exp.size() != 0) exp = q_exp.pop_front();
        else begin exp = 32'h0; unf_m = 1'b1; end
        bus_rd(c_a_data, d, ae);
        check("pop_data", d, exp);
        check("pop_aerr", {31'h0, ae}, 32'h0);
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] d, e;
        logic        ae;
        e        = 32'h0;
        e[0]     = (q_exp.size() == 0);
        e[1]     = (q_exp.size() == DEPTH);
        e[2]     = ovf_m;
        e[3]     = unf_m;
        e[16:8]  = 9'(q_exp.size());
        bus_rd(c_a_status, d, ae);
        check(tag, d, e);
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        ae;
        bus_rd(addr, d, ae);
        check(tag, d, exp);
    endtask

    task automatic clear_flags();
        logic we, wae;
        bus_wr(c_a_ctrl, 32'h2, 4'h1, we, wae);
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    // Push and pop DATA in the same cycle.
    task automatic push_pop(input logic [31:0] d, input string tag);
        logic [31:0] exp_rd, got;
        logic        we;
        if (q_exp.size() != 0) exp_rd = q_exp.pop_front();
        else begin exp_rd = 32'h0; unf_m = 1'b1; end
        q_exp.push_back(d);
        write = 1'b1; write_address = c_a_data; write_data = d; write_byteenable = 4'hF;
        read  = 1'b1; read_address  = c_a_data;
        #2;
        got = read_data;
        we  = write_error;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        check({tag, "_rd"}, got, exp_rd);
        check({tag, "_werr"}, {31'h0, we}, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic        we, wae, ae;

        rst = 1'b1; write = 1'b0; read = 1'b0;
        write_address = 32'h0; write_data = 32'h0; write_byteenable = 4'h0;
        read_address = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_irq", {31'h0, irq}, 32'h0);
        chk_status("reset_status");
        rd_reg("reset_thresh", c_a_thresh, 32'h1);
        rd_reg("reset_ctrl", c_a_ctrl, 32'h0);

        // Basic push/pop ordering
        push_m(32'hA5A5_0001, 4'hF);
        push_m(32'hA5A5_0002, 4'hF);
        chk_status("status_two");
        pop_m();
        pop_m();
        chk_status("status_empty");

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) push_m(32'h1000_0000 + 32'(i * 32'h0101), 4'hF);
        push_m(32'hDEAD_BEEF, 4'hF);
        chk_status("status_ovf_full");
        for (int i = 0; i < DEPTH; i++) pop_m();
        chk_status("status_drained");

        // Underflow and clear
        pop_m();
        chk_status("status_unf");
        clear_flags();
        chk_status("status_cleared");

        // Threshold interrupt
        bus_wr(c_a_thresh, 32'h3, 4'h3, we, wae);
        bus_wr(c_a_ctrl, 32'h100, 4'h2, we, wae);
        rd_reg("ctrl_irq_en", c_a_ctrl, 32'h100);
        push_m(32'h11, 4'hF);
        push_m(32'h22, 4'hF);
        check("irq_after_2", {31'h0, irq}, 32'h0);
        push_m(32'h33, 4'hF);
        check("irq_after_3", {31'h0, irq}, 32'h1);
        pop_m();
        check("irq_after_pop", {31'h0, irq}, 32'h0);
        bus_wr(c_a_ctrl, 32'h0, 4'h2, we, wae);
        pop_m();
        pop_m();

        // Byte strobes and illegal accesses
        push_m(32'h1234_5678, 4'b0101);
        pop_m();
        bus_wr(c_a_status, 32'hFFFF_FFFF, 4'hF, we, wae);
        check("status_wr_werr", {31'h0, we}, 32'h1);
        check("status_wr_waerr", {31'h0, wae}, 32'h0);
        bus_wr(BASE_ADDR + 32'h20, 32'h1, 4'hF, we, wae);
        check("miss_wr_waerr", {31'h0, wae}, 32'h1);
        check("miss_wr_werr", {31'h0, we}, 32'h0);
        bus_rd(BASE_ADDR + 32'h20, d, ae);
        check("miss_rd_aerr", {31'h0, ae}, 32'h1);
        check("miss_rd_data", d, 32'h0);
        bus_rd(BASE_ADDR + 32'h14, d, ae);
        check("unmapped_rd_aerr", {31'h0, ae}, 32'h1);
        chk_status("status_after_errors");

        // Threshold byte strobes
        bus_wr(c_a_thresh, 32'hFFFF_FFFF, 4'h1, we, wae);
        rd_reg("thresh_lo", c_a_thresh, 32'hFF);
        bus_wr(c_a_thresh, 32'h0000_0100, 4'h2, we, wae);
        rd_reg("thresh_hi", c_a_thresh, 32'h1FF);

`ifdef SIMPLE_MAILBOX_PEEK_EN
        push_m(32'h55, 4'hF);
        rd_reg("peek_1", c_a_peek, 32'h55);
        rd_reg("peek_2", c_a_peek, 32'h55);
        chk_status("status_after_peek");
        bus_wr(c_a_peek, 32'h0, 4'hF, we, wae);
        check("peek_wr_werr", {31'h0, we}, 32'h1);
        pop_m();
`else
        bus_rd(c_a_peek, d, ae);
        check("peek_rd_aerr", {31'h0, ae}, 32'h1);
        check("peek_rd_data", d, 32'h0);
        bus_wr(c_a_peek, 32'h0, 4'hF, we, wae);
        check("peek_wr_waerr", {31'h0, wae}, 32'h1);
`endif

        // Simultaneous push+pop on empty, then on full
        push_pop(32'hCAFE_0001, "pp_empty");
        chk_status("status_pp_empty");
        clear_flags();
        pop_m();
        for (int i = 0; i < DEPTH; i++) push_m(32'h2000_0000 + 32'(i), 4'hF);
        push_pop(32'hCAFE_0002, "pp_full");
        chk_status("status_pp_full");
        for (int i = 0; i < DEPTH; i++) pop_m();

        // Flush, and flush racing a pop
        push_m(32'h66, 4'hF);
        push_m(32'h77, 4'hF);
        bus_wr(c_a_ctrl, 32'h1, 4'h1, we, wae);
        q_exp.delete();
        chk_status("status_flush");
        push_m(32'h88, 4'hF);
        write = 1'b1; write_address = c_a_ctrl; write_data = 32'h1; write_byteenable = 4'h1;
        read  = 1'b1; read_address  = c_a_data;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        q_exp.delete();
        chk_status("status_flush_pop");

        // Reset wins over a same-cycle push
        push_m(32'h99, 4'hF);
        bus_wr(c_a_thresh, 32'h5, 4'h3, we, wae);
        rst = 1'b1;
        write = 1'b1; write_address = c_a_data; write_data = 32'hBAD0_0001; write_byteenable = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0; write = 1'b0;
        q_exp.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        chk_status("status_mid_reset");
        rd_reg("thresh_mid_reset", c_a_thresh, 32'h1);
        pop_m();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
